// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
// Op encoding, FSM states and the behavioural 32x32 product.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int DIV_ITER = 32;

  function automatic logic is_signed_op(
    input mdu_op_t op
  );
    return op inside {OP_MULT, OP_DIV,
                      OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_mul_op(
    input mdu_op_t op
  );
    return op inside {OP_MULT, OP_MULTU,
                      OP_MADD, OP_MADDU,
                      OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(
    input mdu_op_t op
  );
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_acc_op(
    input mdu_op_t op
  );
    return op inside {OP_MADD, OP_MADDU,
                      OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub_op(
    input mdu_op_t op
  );
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

  // Low 64 bits of the extended product equal the
  // exact signed or unsigned 64-bit result.
  function automatic logic [63:0] mul64(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn
  );
    logic [63:0] xa;
    logic [63:0] xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// quotient/remainder show the post-iteration value while done=1.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] d;
  logic [32:0] sh;
  logic [32:0] diff;
  logic        fits;

  assign sh        = {r, q[31]};
  assign diff      = sh - {1'b0, d};
  assign fits      = ~diff[32];
  assign quotient  = {q[30:0], fits};
  assign remainder = fits ? diff[31:0] : sh[31:0];
  assign done      = busy & (cnt == 5'(DIV_ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
    end else if (busy) begin
      q   <= quotient;
      r   <= remainder;
      cnt <= cnt + 5'd1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// EXE-stage multiply/divide sequencer with HI/LO result hold.
// Define MDU_MADD_EN to execute MADD/MADDU/MSUB/MSUBU.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Start,
  input  mdu_op_t     EXE_Op,
  input  logic [31:0] EXE_Rs,
  input  logic [31:0] EXE_Rt,
  input  logic [31:0] HI_In,
  input  logic [31:0] LO_In,
  input  logic        EXE_Wr,
  input  logic        Flush_Exception,
  output logic        DIVMULTBusy,
  output logic        MDU_Valid,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        op_ok;
  logic        start;
  logic        sgn_in;
  logic        mul_in;
  logic        div_go;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] div_lo;
  logic [31:0] div_hi;
  logic [63:0] mul_res;
  logic [63:0] mul_final;
  logic [63:0] pipe [MUL_LATENCY];

  assign sgn_in = is_signed_op(EXE_Op);
  assign mul_in = is_mul_op(EXE_Op);

`ifdef MDU_MADD_EN
  assign op_ok = mul_in | is_div_op(EXE_Op);
`else
  assign op_ok = (mul_in & ~is_acc_op(EXE_Op))
               | is_div_op(EXE_Op);
`endif

  assign start = (state == IDLE) & EXE_Start
               & op_ok & ~Flush_Exception;

  assign DIVMULTBusy = start
                     | (state == MUL)
                     | (state == DIV);
  assign MDU_Valid = (state == DONE)
                   & ~Flush_Exception;
  assign HI_Out = hi_q;
  assign LO_Out = lo_q;

  // Product pipeline: stage 0 captures the start cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      if (start && mul_in)
        pipe[0] <= mul64(EXE_Rs, EXE_Rt, sgn_in);
      for (int i = 1; i < MUL_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign mul_res = pipe[MUL_LATENCY-1];

`ifdef MDU_MADD_EN
  mdu_op_t     op_q;
  logic [63:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_NONE;
      acc_q <= '0;
    end else if (start) begin
      op_q  <= EXE_Op;
      acc_q <= {HI_In, LO_In};
    end
  end

  always_comb begin
    mul_final = mul_res;
    if (is_acc_op(op_q))
      mul_final = is_sub_op(op_q)
                ? acc_q - mul_res
                : acc_q + mul_res;
  end
`else
  logic unused_acc;
  assign unused_acc = ^{HI_In, LO_In};
  assign mul_final  = mul_res;
`endif

  // Divider runs on magnitudes; signs are restored here.
  assign div_go = start & is_div_op(EXE_Op)
                & (EXE_Rt != '0);
  assign div_a  = (sgn_in && EXE_Rs[31])
                ? -EXE_Rs : EXE_Rs;
  assign div_b  = (sgn_in && EXE_Rt[31])
                ? -EXE_Rt : EXE_Rt;
  assign div_lo = neg_q ? -div_q : div_q;
  assign div_hi = neg_r ? -div_r : div_r;

  mdu_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_go),
    .abort     (Flush_Exception),
    .dividend  (div_a),
    .divisor   (div_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            neg_q <= sgn_in
                   & (EXE_Rs[31] ^ EXE_Rt[31]);
            neg_r <= sgn_in & EXE_Rs[31];
            if (mul_in) begin
              state <= MUL;
              cnt   <= 5'(MUL_LATENCY - 1);
            end else if (EXE_Rt == '0) begin
              state <= DONE;
              hi_q  <= EXE_Rs;
              lo_q  <= '1;
            end else begin
              state <= DIV;
              cnt   <= 5'(DIV_ITER - 1);
            end
          end
        end
        MUL: begin
          if (Flush_Exception) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state        <= DONE;
            {hi_q, lo_q} <= mul_final;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (Flush_Exception) begin
            state <= IDLE;
          end else if (div_done) begin
            state <= DONE;
            hi_q  <= div_hi;
            lo_q  <= div_lo;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          if (Flush_Exception || EXE_Wr)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table,
// corner-case sequences and randomized ops vs a reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exe_start = 1'b0;
  mdu_op_t     exe_op = OP_NONE;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] hi_in = '0;
  logic [31:0] lo_in = '0;
  logic        exe_wr = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.MUL_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .EXE_Start       (exe_start),
    .EXE_Op          (exe_op),
    .EXE_Rs          (rs),
    .EXE_Rt          (rt),
    .HI_In           (hi_in),
    .LO_In           (lo_in),
    .EXE_Wr          (exe_wr),
    .Flush_Exception (flush),
    .DIVMULTBusy     (busy),
    .MDU_Valid       (valid),
    .HI_Out          (hi_out),
    .LO_Out          (lo_out)
  );

  typedef struct {
    mdu_op_t     op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          go;
    int          cyc;
    logic [63:0] res;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic void add(
    input mdu_op_t op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] h,
    input logic [31:0] l, input bit go,
    input int cyc, input logic [63:0] res);
    vec_t v;
    v.op = op; v.rs = a; v.rt = b;
    v.hi = h; v.lo = l; v.go = go;
    v.cyc = cyc; v.res = res;
    tbl.push_back(v);
  endfunction

  // Reference: plain integer arithmetic on the op's meaning.
  function automatic void model(
    input mdu_op_t op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] h,
    input logic [31:0] l, output bit go,
    output int cyc, output logic [63:0] res);
    longint      sa, sb, q, r, sp;
    logic [63:0] ua, ub, acc, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    acc = {h, l};
    go = 1'b1;
    cyc = LAT + 1;
    res = '0;
    sp = sa * sb;
    case (op)
      OP_MULT:  res = sp;
      OP_MULTU: res = ua * ub;
      OP_MADD:  res = acc + sp;
      OP_MADDU: res = acc + ua * ub;
      OP_MSUB:  res = acc - sp;
      OP_MSUBU: res = acc - ua * ub;
      OP_DIV, OP_DIVU: begin
        cyc = 33;
        if (b == 0) begin
          cyc = 1;
          res = {a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          p = ua / ub;
          acc = ua % ub;
          res = {acc[31:0], p[31:0]};
        end
      end
      default: go = 1'b0;
    endcase
`ifndef MDU_MADD_EN
    if (op inside {OP_MADD, OP_MADDU,
                   OP_MSUB, OP_MSUBU})
      go = 1'b0;
`endif
    if (!go) begin
      cyc = 0;
      res = '0;
    end
  endfunction

  task automatic run_op(input string nm,
    input mdu_op_t op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] h,
    input logic [31:0] l, input bit go,
    input int cyc, input logic [63:0] res,
    input int hold);
    int n;
    @(posedge clk); #1;
    exe_op = op; rs = a; rt = b;
    hi_in = h; lo_in = l;
    exe_wr = 1'b0;
    exe_start = 1'b1;
    if (!go) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({nm, " idle busy"}, 64'(busy), 0);
        check({nm, " idle valid"}, 64'(valid), 0);
      end
      @(posedge clk); #1;
      exe_start = 1'b0;
      exe_op = OP_NONE;
      return;
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy cycles"}, 64'(n), 64'(cyc));
    check({nm, " valid"}, 64'(valid), 1);
    check({nm, " hilo"}, {hi_out, lo_out}, res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, " hold valid"}, 64'(valid), 1);
      check({nm, " hold busy"}, 64'(busy), 0);
      check({nm, " hold hilo"},
            {hi_out, lo_out}, res);
    end
    @(posedge clk); #1;
    exe_wr = 1'b1;
    exe_start = 1'b0;
    @(posedge clk); #1;
    exe_wr = 1'b0;
    exe_op = OP_NONE;
    @(negedge clk);
    check({nm, " idle after wr"}, 64'(valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g;
    int          c, n, vcnt;
    logic [63:0] e;
    mdu_op_t     op;
    logic [31:0] a, b;

    add(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0,
        1, LAT + 1, 64'hFFFF_FFFF_FFFF_FFFA);
    add(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0,
        1, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    add(OP_DIVU, 32'd100, 32'd7, 0, 0,
        1, 33, 64'h0000_0002_0000_000E);
    add(OP_DIVU, 32'h1234_5678, 32'd0, 0, 0,
        1, 1, 64'h1234_5678_FFFF_FFFF);
    add(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
        1, 33, 64'h0000_0000_8000_0000);
    add(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0,
        1, 33, 64'h0000_0001_FFFF_FFFD);
    add(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
        1, LAT + 1, 64'hFFFF_FFFE_0000_0001);
    add(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0,
        1, LAT + 1, 64'h4000_0000_0000_0000);
    add(OP_NONE, 32'd5, 32'd6, 0, 0, 0, 0, 0);
`ifdef MDU_MADD_EN
    add(OP_MADDU, 32'd1, 32'd1, 0, 32'hFFFF_FFFF,
        1, LAT + 1, 64'h0000_0001_0000_0000);
    add(OP_MSUB, 32'd2, 32'd3, 0, 32'd5,
        1, LAT + 1, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_MADD, 32'hFFFF_FFFE, 32'd3, 0, 32'd10,
        1, LAT + 1, 64'h0000_0000_0000_0004);
`else
    add(OP_MADDU, 32'd1, 32'd1, 0, 32'hFFFF_FFFF,
        0, 0, 0);
    add(OP_MSUB, 32'd2, 32'd3, 0, 32'd5,
        0, 0, 0);
`endif

    // Reset state
    #2;
    check("reset busy", 64'(busy), 0);
    check("reset valid", 64'(valid), 0);
    check("reset hilo", {hi_out, lo_out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].op,
             tbl[i].rs, tbl[i].rt, tbl[i].hi,
             tbl[i].lo, tbl[i].go, tbl[i].cyc,
             tbl[i].res, 0);

    // DONE held with EXE_Start asserted
    run_op("hold", OP_DIVU, 32'd100, 32'd7, 0, 0,
           1, 33, 64'h0000_0002_0000_000E, 5);

    // Flush mid-DIV at T+10
    @(posedge clk); #1;
    exe_op = OP_DIV; rs = 32'd1000; rt = 32'd3;
    exe_start = 1'b1;
    @(negedge clk);
    check("flush start busy", 64'(busy), 1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    exe_start = 1'b0;
    @(negedge clk);
    check("flush cycle busy", 64'(busy), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush after busy", 64'(busy), 0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid || busy) vcnt++;
    end
    check("flush no valid", 64'(vcnt), 0);
    run_op("post flush", OP_MULTU, 32'd2, 32'd3,
           0, 0, 1, LAT + 1, 64'd6, 0);

    // Flush while in DONE discards the result
    @(posedge clk); #1;
    exe_op = OP_MULT; rs = 32'd5; rt = 32'd5;
    exe_start = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("done flush pre valid", 64'(valid), 1);
    @(posedge clk); #1;
    flush = 1'b1;
    exe_start = 1'b0;
    #1;
    check("done flush valid", 64'(valid), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("done flush idle", 64'(valid | busy), 0);

    // Asynchronous reset mid-DIV
    @(posedge clk); #1;
    exe_op = OP_DIV; rs = 32'h0000_FFFF; rt = 32'h10;
    exe_start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exe_start = 1'b0;
    #1;
    check("rst busy", 64'(busy), 0);
    check("rst valid", 64'(valid), 0);
    check("rst hilo", {hi_out, lo_out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exe_op = OP_NONE;

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      op = mdu_op_t'($urandom_range(0, 8));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      hi_in = $urandom;
      lo_in = $urandom;
      model(op, a, b, hi_in, lo_in, g, c, e);
      run_op($sformatf("rnd%0d op%0d", k, op), op,
             a, b, hi_in, lo_in, g, c, e,
             $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
